// File: rtl/posit_encoder.sv
// Multi-cycle Posit<32,3> field packer: sign/regime/exponent/fraction -> 32-bit posit.
// Define POSIT_ENC_RNE_EN for round-to-nearest-even; otherwise the magnitude is truncated.
module posit_encoder #(
    parameter int N  = 32,
    parameter int ES = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          received,
    input  logic          sign,
    input  logic          ZERO,
    input  logic          NAR,
    input  logic [5:0]    k,
    input  logic [ES-1:0] exp_value,
    input  logic [N-1:0]  mantissa,
    output logic [N-1:0]  posit_num,
    output logic          done,
    output logic          inexact
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSEMBLE,
        S_ROUND,
        S_NEGATE,
        S_DONE
    } state_t;

    state_t        state_q;
    logic          sign_q, zero_q, nar_q;
    logic [5:0]    k_q;
    logic [2:0]    exp_q;
    logic [30:0]   frac_q;
    logic [65:0]   str_q;
    logic [30:0]   mag_q;
    logic          rinx_q;
    logic [31:0]   res_q;
    logic          res_inx_q;
    logic [31:0]   posit_q;
    logic          inexact_q;
    logic          done_q;

    logic          unused_hidden;
    logic [4:0]    shamt;
    logic [65:0]   base;
    logic [65:0]   str_d;
    logic [30:0]   mag;
    logic          guard, sticky, inc;
    logic [31:0]   sum;
    logic          sat_hi, sat_lo, carry, underflow;
    logic [30:0]   mag_d;
    logic          rinx_d;
    logic [31:0]   res_d;
    logic          res_inx_d;

    assign unused_hidden = mantissa[31];

    // Regime via one arithmetic shift: the seed MSB is the run bit, the next bit its terminator.
    // For k<0, ~k equals -k-1, the number of extra zeros beyond the first.
    always_comb begin
        shamt = k_q[5] ? ~k_q[4:0] : k_q[4:0];
        base  = {~k_q[5], k_q[5], exp_q, frac_q, 30'b0};
        str_d = $signed(base) >>> shamt;
    end

    always_comb begin
        mag    = str_q[65:35];
        guard  = str_q[34];
        sticky = |str_q[33:0];
`ifdef POSIT_ENC_RNE_EN
        inc    = guard & (sticky | mag[0]);
`else
        inc    = 1'b0;
`endif
        sum       = {1'b0, mag} + {31'b0, inc};
        sat_hi    = (k_q == 6'd31);
        sat_lo    = k_q[5] & (k_q[4:1] == 4'b0000);
        carry     = sum[31];
        underflow = (sum[30:0] == '0);
        if (sat_hi || carry) begin
            mag_d = '1;
        end else if (sat_lo || underflow) begin
            mag_d = 31'd1;
        end else begin
            mag_d = sum[30:0];
        end
        rinx_d = guard | sticky | sat_hi | sat_lo | carry | underflow;
    end

    always_comb begin
        res_inx_d = rinx_q;
        if (nar_q) begin
            res_d     = 32'h8000_0000;
            res_inx_d = 1'b0;
        end else if (zero_q) begin
            res_d     = '0;
            res_inx_d = 1'b0;
        end else if (sign_q) begin
            res_d = -{1'b0, mag_q};
        end else begin
            res_d = {1'b0, mag_q};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            nar_q     <= 1'b0;
            k_q       <= '0;
            exp_q     <= '0;
            frac_q    <= '0;
            str_q     <= '0;
            mag_q     <= '0;
            rinx_q    <= 1'b0;
            res_q     <= '0;
            res_inx_q <= 1'b0;
            posit_q   <= '0;
            inexact_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sign_q  <= sign;
                        zero_q  <= ZERO;
                        nar_q   <= NAR;
                        k_q     <= k;
                        exp_q   <= exp_value;
                        frac_q  <= mantissa[30:0];
                        state_q <= S_ASSEMBLE;
                    end
                end
                S_ASSEMBLE: begin
                    str_q   <= str_d;
                    state_q <= S_ROUND;
                end
                S_ROUND: begin
                    mag_q   <= mag_d;
                    rinx_q  <= rinx_d;
                    state_q <= S_NEGATE;
                end
                S_NEGATE: begin
                    res_q     <= res_d;
                    res_inx_q <= res_inx_d;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    // First DONE cycle loads the output registers; acknowledge is honoured once done is visible.
                    posit_q   <= res_q;
                    inexact_q <= res_inx_q;
                    if (done_q && received) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign posit_num = posit_q;
    assign done      = done_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_posit_encoder.sv
// Directed-vector bench for posit_encoder: field table plus handshake and reset sequences.
module tb_posit_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, received, sign, ZERO, NAR;
    logic [5:0]  k;
    logic [2:0]  exp_value;
    logic [31:0] mantissa;
    logic [31:0] posit_num;
    logic        done, inexact;

    int total = 0;
    int bad   = 0;

    posit_encoder #(.N(32), .ES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .received  (received),
        .sign      (sign),
        .ZERO      (ZERO),
        .NAR       (NAR),
        .k         (k),
        .exp_value (exp_value),
        .mantissa  (mantissa),
        .posit_num (posit_num),
        .done      (done),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic        zro;
        logic        nar;
        logic [5:0]  kv;
        logic [2:0]  ev;
        logic [31:0] mv;
        logic [31:0] want_p;
        logic        want_i;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic drive(input vec_t v);
        sign      = v.sgn;
        ZERO      = v.zro;
        NAR       = v.nar;
        k         = v.kv;
        exp_value = v.ev;
        mantissa  = v.mv;
    endtask

    // Waits (bounded) for done after the start edge; returns the number of edges taken.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 10) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run(input vec_t v);
        int cyc;
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check({v.name, " latency"}, 32'(cyc), 32'd4);
        check({v.name, " posit"}, posit_num, v.want_p);
        check({v.name, " inexact"}, {31'b0, inexact}, {31'b0, v.want_i});
        received = 1'b1;
        @(posedge clk);
        @(negedge clk);
        received = 1'b0;
        check({v.name, " done clears"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int   cyc;
        logic [31:0] held;
        vec_t v;

        vecs[0]  = '{"zero",        0, 1, 0, 6'd0,  3'd0, 32'h8000_0000, 32'h0000_0000, 0};
        vecs[1]  = '{"nar",         0, 1, 1, 6'd0,  3'd0, 32'h8000_0000, 32'h8000_0000, 0};
        vecs[2]  = '{"one",         0, 0, 0, 6'd0,  3'd0, 32'h8000_0000, 32'h4000_0000, 0};
        vecs[3]  = '{"minus_one",   1, 0, 0, 6'd0,  3'd0, 32'h8000_0000, 32'hC000_0000, 0};
        vecs[4]  = '{"k_m1",        0, 0, 0, 6'h3F, 3'd0, 32'h8000_0000, 32'h2000_0000, 0};
        vecs[5]  = '{"k_m1_neg",    1, 0, 0, 6'h3F, 3'd0, 32'h8000_0000, 32'hE000_0000, 0};
        vecs[6]  = '{"k_p1_e5",     0, 0, 0, 6'd1,  3'd5, 32'h8000_0000, 32'h6A00_0000, 0};
        vecs[7]  = '{"sat_max",     0, 0, 0, 6'd31, 3'd0, 32'h8000_0000, 32'h7FFF_FFFF, 1};
        vecs[8]  = '{"sat_min",     0, 0, 0, 6'h20, 3'd0, 32'h8000_0000, 32'h0000_0001, 1};
        vecs[9]  = '{"sat_max_neg", 1, 0, 0, 6'd31, 3'd0, 32'h8000_0000, 32'h8000_0001, 1};
        vecs[10] = '{"k30_full",    0, 0, 0, 6'd30, 3'd7, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1};
        vecs[11] = '{"k_m30_exact", 0, 0, 0, 6'h22, 3'd0, 32'h8000_0000, 32'h0000_0001, 0};
`ifdef POSIT_ENC_RNE_EN
        vecs[12] = '{"tie_even",    0, 0, 0, 6'd0,  3'd0, 32'h8000_0030, 32'h4000_0002, 1};
        vecs[13] = '{"above_half",  0, 0, 0, 6'd0,  3'd0, 32'h8000_0018, 32'h4000_0001, 1};
        vecs[14] = '{"ripple",      0, 0, 0, 6'h3D, 3'd7, 32'hFFFF_FFFF, 32'h1000_0000, 1};
`else
        vecs[12] = '{"tie_even",    0, 0, 0, 6'd0,  3'd0, 32'h8000_0030, 32'h4000_0001, 1};
        vecs[13] = '{"above_half",  0, 0, 0, 6'd0,  3'd0, 32'h8000_0018, 32'h4000_0000, 1};
        vecs[14] = '{"ripple",      0, 0, 0, 6'h3D, 3'd7, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 1};
`endif

        rst = 1'b0;
        start = 1'b0;
        received = 1'b0;
        drive(vecs[2]);
        repeat (2) @(negedge clk);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset posit", posit_num, 32'd0);
        check("reset inexact", {31'b0, inexact}, 32'd0);
        rst = 1'b1;

        run('{"tie_lsb0", 0, 0, 0, 6'd0, 3'd0, 32'h8000_0010, 32'h4000_0000, 1});
        for (int unsigned i = 0; i < 15; i++) begin
            run(vecs[i]);
        end

        // Start pulse with different fields while in ASSEMBLE must not disturb the result.
        v = vecs[6];
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(vecs[4]);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("hs latency", 32'(cyc + 1), 32'd4);
        check("hs posit", posit_num, 32'h6A00_0000);
        held = posit_num;
        for (int unsigned i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hs hold done", {31'b0, done}, 32'd1);
            check("hs hold posit", posit_num, held);
        end
        received = 1'b1;
        @(posedge clk);
        @(negedge clk);
        received = 1'b0;
        check("hs ack done", {31'b0, done}, 32'd0);
        check("hs idle posit", posit_num, 32'h6A00_0000);
        repeat (6) @(negedge clk);
        check("hs no extra op", {31'b0, done}, 32'd0);

        // Reset asserted while the FSM is in ROUND.
        @(negedge clk);
        drive(vecs[3]);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset done", {31'b0, done}, 32'd0);
        check("midreset posit", posit_num, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run(vecs[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/posit_encoder.md
Name: posit_encoder

Overview:
- Multi-cycle Posit<32,3> encoder: packs sign / regime k / exponent / mantissa fields into a 32-bit posit word.
- Exact inverse of posit_decoder's field outputs, with the same start/done/received handshake.
- Sits at the output of the posit arithmetic datapath; feeds posit_num back to memory/bus.

Parameters:
- N, 32, posit word width; only 32 is supported and verified.
- ES, 3, exponent field width; only 3 is supported and verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  level request; sampled only in IDLE.
- received  input  1  consumer acknowledge; sampled only in DONE.
- sign  input  1  1 = negative.
- ZERO  input  1  encode zero.
- NAR  input  1  encode Not-a-Real; priority over ZERO.
- k  input  6  signed two's-complement regime value, range -32..31.
- exp_value  input  3  unsigned exponent, 0..7.
- mantissa  input  32  1.f significand: bit31 = hidden bit (ignored), bits 30:0 = fraction.
- posit_num  output  32  encoded posit.
- done  output  1  result valid; held until acknowledged.
- inexact  output  1  1 if any nonzero bits were discarded (guard or sticky) or saturation occurred.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - posit_num=0, done=0, inexact=0; all internal registers cleared.
  - Reset mid-operation aborts with no partial output.
- FSM states: IDLE -> ASSEMBLE -> ROUND -> NEGATE -> DONE -> IDLE.
- IDLE:
  - If start=1 at an edge, capture all field inputs and go to ASSEMBLE.
  - Inputs are not re-sampled after capture; later input changes have no effect.
- ASSEMBLE:
  - Regime bits: k>=0 gives (k+1) ones then a 0; k<0 gives (-k) zeros then a 1.
  - Build the string {regime, exp_value[2:0], mantissa[30:0]}, MSB-aligned in a 66-bit register.
  - Top 31 bits form the magnitude. Next bit = guard. OR of all remaining bits = sticky.
- ROUND:
  - Round-to-nearest-even: increment the magnitude if guard & (sticky | magnitude[0]).
  - Saturation:
    - k>=31, or a carry out of bit 30, gives magnitude 0x7FFFFFFF (maxpos).
    - k<=-31, or a magnitude of 0 after rounding, gives 0x00000001 (minpos).
    - A nonzero value never encodes to zero or NaR.
- NEGATE:
  - If sign=1, result = two's complement of {1'b0, magnitude}; otherwise result = {1'b0, magnitude}.
  - Special overrides: NAR gives 0x80000000, else ZERO gives 0x00000000; both set inexact=0.
- DONE:
  - posit_num and inexact are registered on entry and stable for the whole state; done=1.
  - When received=1, go to IDLE next edge; done=0 in IDLE.
- Latency: start sampled at edge E0; done=1 and posit_num valid after edge E0+4 (4 cycles).
- Hazards:
  - start while not IDLE: ignored.
  - received outside DONE: ignored.
  - start and received both high in DONE: return to IDLE; a new capture needs start=1 at a later edge in IDLE.
  - posit_num holds its last value in IDLE until the next DONE entry.

Optional Feature:
- Macro: POSIT_ENC_RNE_EN
  - Defined: round-to-nearest-even as specified above.
  - Undefined: truncation. The guard/sticky increment is removed, but guard/sticky still drive inexact, and minpos/maxpos saturation still applies.
  - The ROUND state stays in both builds, so latency is identical.

Test Plan:
- ZERO=1, NAR=0, start pulse -> done after 4 cycles, posit_num=0x00000000, inexact=0. Then NAR=1 with ZERO=1 -> 0x80000000.
- sign=0, k=0, exp=0, mantissa=0x80000000 -> 0x40000000. Same fields with sign=1 -> 0xC0000000. k=-1 (6'h3F), sign=0 -> 0x20000000.
- Saturation:
  - k=31 -> 0x7FFFFFFF, inexact=1.
  - k=-32 -> 0x00000001, inexact=1.
  - sign=1, k=31 -> 0x80000001.
- Rounding, k=0, exp=0 (RNE build):
  - mantissa=0x80000010 (tie, lsb=0) -> 0x40000000.
  - 0x80000030 (tie, lsb=1) -> 0x40000002.
  - 0x80000018 -> 0x40000001.
  - inexact=1 for all three.
  - Without the macro: 0x40000000 / 0x40000001 / 0x40000000.
- Handshake:
  - Hold received=0 for 20 cycles after done: done stays 1, posit_num stable.
  - start pulses during ASSEMBLE are ignored.
  - received=1 -> done=0 the next cycle.
- Deassert reset (rst=0) during ROUND -> done=0 and posit_num=0 immediately. After release, a fresh start with k=0 yields 0x40000000 in 4 cycles.
